// File: rtl/serial_frame_rx_pkg.sv
// Shared line-level constants and receiver state encoding; also used by the
// matching serializer so both ends agree on idle and start levels.
package serial_frame_rx_pkg;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DATA      = 2'd1;
    localparam logic [1:0] ST_STOP      = 2'd2;
    localparam logic [1:0] ST_WAIT_HIGH = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        DATA      = ST_DATA,
        STOP      = ST_STOP,
        WAIT_HIGH = ST_WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/out_buffer_1deep.sv
// Single-entry valid/ready holding register; a load that finds the entry
// occupied and not draining is dropped and flagged as an overrun pulse.
module out_buffer_1deep #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    output logic         overrun
);

    logic [N-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         overrun_q, overrun_d;
    logic         can_load;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        // The entry is reusable if empty or being consumed on this very edge.
        can_load  = !valid_q || out_ready;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            if (can_load) begin
                data_d  = load_data;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/serial_frame_rx.sv
// LSB-first serial frame receiver: start bit, N data bits, stop bit, with the
// assembled word presented on a one-deep valid/ready buffer.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         serial_in,
    input  logic         bit_en,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         frame_err,
    output logic         overrun,
    output logic         busy
);

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       sreg_q, sreg_d;
    logic               frame_err_q, frame_err_d;
    logic               busy_q;
    logic               load;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sreg_d      = sreg_q;
        frame_err_d = 1'b0;
        load        = 1'b0;

        if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (serial_in == START_LEVEL) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    sreg_d = {serial_in, sreg_q[N-1:1]};
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_d = STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (serial_in == IDLE_LEVEL) begin
                        load    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    // A stuck-low line must not be mistaken for fresh start bits.
                    if (serial_in == IDLE_LEVEL) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sreg_q      <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sreg_q      <= sreg_d;
            frame_err_q <= frame_err_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    out_buffer_1deep #(
        .N(N)
    ) u_out_buffer (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (sreg_q),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (N=4) with hand-computed expectations.
module tb_serial_frame_rx;

    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic         serial_in;
    logic         bit_en;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         frame_err;
    logic         overrun;
    logic         busy;

    int n_checks;
    int n_fail;

    serial_frame_rx #(
        .N(N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .bit_en    (bit_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bit, let one rising edge sample it, settle 1 time unit.
    task automatic send_bit(input logic b);
        serial_in = b;
        @(posedge clk);
        #1;
    endtask

    // Start bit, LSB-first data, stop bit; out_ready set just before the stop bit.
    task automatic send_frame(input logic [N-1:0] d, input logic stop, input logic rdy_stop);
        send_bit(1'b0);
        for (int i = 0; i < N; i++) send_bit(d[i]);
        out_ready = rdy_stop;
        send_bit(stop);
    endtask

    // Same bit, but two bit_en=0 cycles precede the sampling cycle.
    task automatic send_bit_strobed(input logic b, input logic exp_busy, input logic [N-1:0] exp_data);
        serial_in = b;
        bit_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("strobe_hold_busy", busy, exp_busy);
            chk("strobe_hold_data", out_data, exp_data);
        end
        bit_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        serial_in = 1'b1;
        bit_en    = 1'b1;
        out_ready = 1'b0;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 4'h0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        reset = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);

        // Test 1: pending word plus mid-frame reset clears everything at once.
        send_frame(4'h7, 1'b1, 1'b0);
        chk("t1_pre_valid", out_valid, 1'b1);
        chk("t1_pre_data", out_data, 4'h7);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("t1_mid_busy", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("t1_async_busy", busy, 1'b0);
        chk("t1_async_valid", out_valid, 1'b0);
        chk("t1_async_data", out_data, 4'h0);
        serial_in = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        send_bit(1'b1);
        send_frame(4'h2, 1'b1, 1'b1);
        chk("t1_after_data", out_data, 4'h2);
        chk("t1_after_valid", out_valid, 1'b1);

        // Test 2: continuous frame 4'hB.
        send_bit(1'b1);
        chk("t1_drain_valid", out_valid, 1'b0);
        send_bit(1'b1);
        send_frame(4'hB, 1'b1, 1'b1);
        chk("t2_data", out_data, 4'hB);
        chk("t2_valid", out_valid, 1'b1);
        chk("t2_ferr", frame_err, 1'b0);
        chk("t2_ovr", overrun, 1'b0);
        chk("t2_busy", busy, 1'b0);
        send_bit(1'b1);
        chk("t2_drain_valid", out_valid, 1'b0);

        // Test 3: framing error, stuck-low line, then recovery.
        send_frame(4'h5, 1'b0, 1'b1);
        chk("t3_ferr", frame_err, 1'b1);
        chk("t3_valid", out_valid, 1'b0);
        chk("t3_busy", busy, 1'b1);
        send_bit(1'b0);
        chk("t3_ferr_pulse", frame_err, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        chk("t3_wait_busy", busy, 1'b1);
        chk("t3_wait_valid", out_valid, 1'b0);
        send_bit(1'b1);
        chk("t3_idle_busy", busy, 1'b0);
        send_frame(4'h3, 1'b1, 1'b1);
        chk("t3_data", out_data, 4'h3);
        chk("t3_valid2", out_valid, 1'b1);
        send_bit(1'b1);

        // Test 4: overrun with a blocked consumer.
        out_ready = 1'b0;
        send_frame(4'hA, 1'b1, 1'b0);
        chk("t4_first_data", out_data, 4'hA);
        chk("t4_first_ovr", overrun, 1'b0);
        send_frame(4'h6, 1'b1, 1'b0);
        chk("t4_ovr", overrun, 1'b1);
        chk("t4_hold_data", out_data, 4'hA);
        chk("t4_hold_valid", out_valid, 1'b1);
        send_bit(1'b1);
        chk("t4_ovr_pulse", overrun, 1'b0);
        out_ready = 1'b1;
        send_bit(1'b1);
        chk("t4_drain_valid", out_valid, 1'b0);

        // Test 5: drain and load on the same edge.
        out_ready = 1'b0;
        send_frame(4'hC, 1'b1, 1'b0);
        chk("t5_c_data", out_data, 4'hC);
        send_frame(4'h9, 1'b1, 1'b1);
        chk("t5_ovr", overrun, 1'b0);
        chk("t5_valid", out_valid, 1'b1);
        chk("t5_data", out_data, 4'h9);
        send_bit(1'b1);
        chk("t5_drain_valid", out_valid, 1'b0);

        // Test 6: bit_en every third cycle, frame 4'hE.
        send_bit_strobed(1'b0, 1'b0, 4'h9);
        chk("t6_start_busy", busy, 1'b1);
        send_bit_strobed(1'b0, 1'b1, 4'h9);
        send_bit_strobed(1'b1, 1'b1, 4'h9);
        send_bit_strobed(1'b1, 1'b1, 4'h9);
        send_bit_strobed(1'b1, 1'b1, 4'h9);
        send_bit_strobed(1'b1, 1'b1, 4'h9);
        chk("t6_data", out_data, 4'hE);
        chk("t6_valid", out_valid, 1'b1);
        chk("t6_ferr", frame_err, 1'b0);
        chk("t6_busy", busy, 1'b0);
        send_bit(1'b1);
        chk("t6_drain_valid", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
